m_stage: RTL

Memory stage of the five-stage MIPS pipeline: E→M pipeline register, byte-addressable data memory, store-data forwarding from W, and load extension. Produces the write-back bundle (`M_A3`, `M_PC`, `M_Reg_Data`, `M_Reg_Write`) consumed directly by the M→W register. It also produces `M_FWD_Data` for the hazard/forwarding unit.

---
 rtl/m_stage_pkg.sv | 35 +++
 rtl/m_dm.sv | 37 +++
 rtl/m_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/m_stage_pkg.sv
// Shared definitions for the memory stage: operation codes, the E->M pipeline
// bundle and the default data-memory depth.
package m_stage_pkg;

  localparam int DM_WORDS_DEF = 3072;
  localparam int DM_AW        = 12;

  typedef enum logic [2:0] {
    MEM_WORD   = 3'd0,
    MEM_HALF_S = 3'd1,
    MEM_HALF_U = 3'd2,
    MEM_BYTE_S = 3'd3,
    MEM_BYTE_U = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_PC8  = 2'd2,
    SRC_ZERO = 2'd3
  } reg_src_e;

  typedef struct packed {
    logic [4:0]  a3;
    logic [4:0]  a2;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] rt_data;
    logic        reg_write;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic [1:0]  reg_src;
  } m_pipe_t;

endpackage

// File: rtl/m_dm.sv
// Word-organised data memory: byte-enable write on the rising edge,
// combinational read, out-of-range accesses ignored on write and read as zero.
module m_dm
  import m_stage_pkg::*;
#(
  parameter int DEPTH = DM_WORDS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       i_be,
  input  logic [DM_AW-1:0] i_index,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  localparam logic [DM_AW:0] DEPTH_W = (DM_AW + 1)'(DEPTH);

  logic [31:0] r_mem [DEPTH];
  logic        w_in_range;

  assign w_in_range = ({1'b0, i_index} < DEPTH_W);

  // NOTE: the array is cleared by the async reset because the pipeline relies
  // on an all-zero memory after reset; this costs a flop array, not a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_index][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = w_in_range ? r_mem[i_index] : '0;

endmodule

// File: rtl/m_stage.sv
// MIPS memory stage: E->M pipeline register, store-data forwarding from W,
// byte-lane store/load with extension, and write-back / forwarding selection.
module m_stage
  import m_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_M_RegWE,
  input  logic        E_M_clear,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  E_A2,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_ALU_Out,
  input  logic [31:0] E_RT_Data,
  input  logic        E_Reg_Write,
  input  logic        E_Mem_Write,
  input  logic [2:0]  E_Mem_Op,
  input  logic [1:0]  E_Reg_Src,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_Reg_Data,
  input  logic        W_Reg_Write,
  output logic [4:0]  M_A3,
  output logic [31:0] M_PC,
  output logic [31:0] M_Reg_Data,
  output logic        M_Reg_Write,
  output logic [31:0] M_FWD_Data,
  output logic [4:0]  M_A2
);

  m_pipe_t     r_pipe;
  m_pipe_t     w_e_bundle;
  logic [31:0] w_store_data;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [31:0] w_rdata;
  logic [31:0] w_load_val;
  logic [31:0] w_pc8;
  logic [1:0]  w_lane;

  assign w_e_bundle = '{a3: E_A3, a2: E_A2, pc: E_PC, alu_out: E_ALU_Out,
                        rt_data: E_RT_Data, reg_write: E_Reg_Write,
                        mem_write: E_Mem_Write, mem_op: E_Mem_Op,
                        reg_src: E_Reg_Src};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_pipe <= '0;
    else if (E_M_clear) r_pipe <= '0;
    else if (E_M_RegWE) r_pipe <= w_e_bundle;
  end

  assign w_lane = r_pipe.alu_out[1:0];
  assign w_pc8  = r_pipe.pc + 32'd8;

  // W result written this cycle is newer than the rt value read back in E.
  assign w_store_data = (W_Reg_Write && (W_A3 != 5'd0) && (W_A3 == r_pipe.a2))
                        ? W_Reg_Data : r_pipe.rt_data;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = w_store_data;
    if (r_pipe.mem_write) begin
      case (r_pipe.mem_op)
        MEM_HALF_S, MEM_HALF_U: begin
          w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{w_store_data[15:0]}};
        end
        MEM_BYTE_S, MEM_BYTE_U: begin
          w_be    = 4'b0001 << w_lane;
          w_wdata = {4{w_store_data[7:0]}};
        end
        default: w_be = 4'b1111;
      endcase
    end
  end

  m_dm #(.DEPTH(DM_WORDS)) u_dm (
    .clk     (clk),
    .reset   (reset),
    .i_be    (w_be),
    .i_index (r_pipe.alu_out[13:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_load_val = w_rdata;
    case (r_pipe.mem_op)
      MEM_HALF_S: w_load_val = w_lane[1] ? {{16{w_rdata[31]}}, w_rdata[31:16]}
                                         : {{16{w_rdata[15]}}, w_rdata[15:0]};
      MEM_HALF_U: w_load_val = w_lane[1] ? {16'd0, w_rdata[31:16]}
                                         : {16'd0, w_rdata[15:0]};
      MEM_BYTE_S, MEM_BYTE_U: begin
        w_load_val = {24'd0, w_rdata[8*w_lane +: 8]};
        if (r_pipe.mem_op == MEM_BYTE_S && w_load_val[7])
          w_load_val[31:8] = '1;
      end
      default: w_load_val = w_rdata;
    endcase
  end

  // Load data is never forwarded: it arrives too late in the M cycle.
  always_comb begin
    M_Reg_Data = '0;
    M_FWD_Data = '0;
    case (r_pipe.reg_src)
      SRC_ALU: begin
        M_Reg_Data = r_pipe.alu_out;
        M_FWD_Data = r_pipe.alu_out;
      end
      SRC_MEM: begin
        M_Reg_Data = w_load_val;
        M_FWD_Data = r_pipe.alu_out;
      end
      SRC_PC8: begin
        M_Reg_Data = w_pc8;
        M_FWD_Data = w_pc8;
      end
      default: begin
        M_Reg_Data = '0;
        M_FWD_Data = '0;
      end
    endcase
  end

  assign M_A3        = r_pipe.a3;
  assign M_A2        = r_pipe.a2;
  assign M_PC        = r_pipe.pc;
  assign M_Reg_Write = r_pipe.reg_write;

endmodule
